// File: rtl/irq_ctrl_cpu.sv
// Memory-mapped interrupt controller: synchronizes raw request lines, latches
// pending bits (edge or level per source) and drives one level IRQ to the CPU.
module irq_ctrl_cpu #(
  parameter logic [31:0] BaseAddress     = 32'h0,
  parameter int unsigned address_width   = 16,
  parameter int unsigned data_width      = 32,
  parameter int unsigned NumSources      = 8,
  parameter int unsigned Address_Wording = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
  output logic [data_width-1:0]    data_o,
  input  logic [NumSources-1:0]    irq_src_i,
  output logic                     irq_o
);

  localparam int unsigned NumRegs = 6;
  localparam logic [2:0] RegPending = 3'd0;
  localparam logic [2:0] RegEnable  = 3'd1;
  localparam logic [2:0] RegClear   = 3'd2;
  localparam logic [2:0] RegMode    = 3'd3;
  localparam logic [2:0] RegActive  = 3'd4;
  localparam logic [2:0] RegId      = 3'd5;

  logic [NumSources-1:0] sync1_q, sync2_q, hist_q;
  logic [NumSources-1:0] pending_q, enable_q, mode_q;
  logic [NumSources-1:0] pending_d, enable_d, mode_d;
  logic [NumSources-1:0] set_v, clr_mask, active_v;
  logic [data_width-1:0] rd_v, id_v;
  logic                  hit;
  logic [2:0]            idx;
  logic                  wr_en;
  logic                  unused_data;

  assign unused_data = ^data_i;

  // Address decode: exact match on one of the register slots
  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (address_i == address_width'(BaseAddress + i * Address_Wording)) begin
        hit = 1'b1;
        idx = 3'(i);
      end
    end
  end

  assign wr_en    = rd_wr_i && hit;
  assign active_v = pending_q & enable_q;

  // Edge sources latch on synced 0->1, level sources every cycle while high
  assign set_v    = (mode_q & sync2_q & ~hist_q) | (~mode_q & sync2_q);
  assign clr_mask = (wr_en && idx == RegClear) ? data_i[NumSources-1:0] : '0;

  always_comb begin
    pending_d = (pending_q & ~clr_mask) | set_v;
    enable_d  = enable_q;
    mode_d    = mode_q;
    if (wr_en && idx == RegEnable) enable_d = data_i[NumSources-1:0];
    if (wr_en && idx == RegMode)   mode_d   = data_i[NumSources-1:0];
  end

  // Lowest-index active source, all ones when nothing is active
  always_comb begin
    id_v = '1;
    for (int i = int'(NumSources) - 1; i >= 0; i--) begin
      if (active_v[i]) id_v = data_width'(unsigned'(i));
    end
  end

  always_comb begin
    rd_v = '0;
    if (hit) begin
      case (idx)
        RegPending: rd_v = data_width'(pending_q);
        RegEnable:  rd_v = data_width'(enable_q);
        RegMode:    rd_v = data_width'(mode_q);
        RegActive:  rd_v = data_width'(active_v);
        RegId:      rd_v = id_v;
        default:    rd_v = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      data_o    <= '0;
      irq_o     <= 1'b0;
    end else begin
      sync1_q   <= irq_src_i;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      data_o    <= rd_v;
      irq_o     <= |active_v;
    end
  end

endmodule

// File: tb/tb_irq_ctrl_cpu.sv
// Randomized and directed checks of irq_ctrl_cpu against a cycle-level
// behavioural model of the register map and interrupt latching rules.
module tb_irq_ctrl_cpu;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [15:0] address_i;
  logic [31:0] data_i;
  logic        rd_wr_i;
  logic [31:0] data_o;
  logic [7:0]  irq_src_i;
  logic        irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: raw samples seen at the last three edges, plus registers
  logic [7:0]  m_samp [1:3];
  logic [7:0]  m_pend, m_en, m_mode;
  logic        m_irq;
  logic [31:0] m_data;
  logic [7:0]  src_v;

  irq_ctrl_cpu dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .address_i (address_i),
    .data_i    (data_i),
    .rd_wr_i   (rd_wr_i),
    .data_o    (data_o),
    .irq_src_i (irq_src_i),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [7:0] act;
    act = m_pend & m_en;
    if (a[1:0] != 2'b00 || a >= 16'd24) return 32'h0;
    case (a >> 2)
      16'd0: return {24'h0, m_pend};
      16'd1: return {24'h0, m_en};
      16'd3: return {24'h0, m_mode};
      16'd4: return {24'h0, act};
      16'd5: begin
        for (int i = 0; i < 8; i++) if (act[i]) return 32'(i);
        return 32'hFFFF_FFFF;
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 1; i <= 3; i++) m_samp[i] = 8'h0;
    m_pend = 8'h0; m_en = 8'h0; m_mode = 8'h0; m_irq = 1'b0; m_data = 32'h0;
  endtask

  // Apply the rules at one clock edge, using the inputs present before it
  task automatic m_edge(input logic [7:0] src, input logic [15:0] a,
                        input logic [31:0] wd, input logic wr);
    logic [7:0] now_v, before_v, setv, clr;
    m_data   = m_read(a);
    m_irq    = |(m_pend & m_en);
    now_v    = m_samp[2];
    before_v = m_samp[3];
    setv = 8'h0;
    for (int i = 0; i < 8; i++)
      setv[i] = m_mode[i] ? (now_v[i] && !before_v[i]) : now_v[i];
    clr    = (wr && a == 16'd8) ? wd[7:0] : 8'h0;
    m_pend = (m_pend & ~clr) | setv;
    if (wr && a == 16'd4)  m_en   = wd[7:0];
    if (wr && a == 16'd12) m_mode = wd[7:0];
    m_samp[3] = m_samp[2];
    m_samp[2] = m_samp[1];
    m_samp[1] = src;
  endtask

  task automatic step(input logic [15:0] a, input logic [31:0] wd, input logic wr);
    irq_src_i = src_v;
    address_i = a;
    data_i    = wd;
    rd_wr_i   = wr;
    @(posedge clk_i);
    m_edge(src_v, a, wd, wr);
    @(negedge clk_i);
    check_eq("irq", {31'h0, irq_o}, {31'h0, m_irq});
    check_eq("data", data_o, m_data);
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [31:0] wd);
    step(a, wd, 1'b1);
  endtask

  task automatic rd_reg(input logic [15:0] a);
    step(a, 32'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'd0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    #1;
    check_eq("rst_irq", {31'h0, irq_o}, 32'h0);
    check_eq("rst_data", data_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      irq_src_i = 8'($urandom);
      @(negedge clk_i);
      check_eq("rst_hold_irq", {31'h0, irq_o}, 32'h0);
      check_eq("rst_hold_data", data_o, 32'h0);
    end
    m_reset();
    src_v = 8'h0;
    irq_src_i = 8'h0;
    reset_n_i = 1'b1;
  endtask

  logic [7:0] irq_seen;

  initial begin
    reset_n_i = 1'b1;
    address_i = '0; data_i = '0; rd_wr_i = 1'b0; irq_src_i = '0; src_v = '0;
    m_reset();
    @(negedge clk_i);

    // T1 reset with sources toggling, then every register reads reset state
    do_reset();
    for (int r = 0; r < 6; r++) rd_reg(16'(r * 4));
    rd_reg(16'd0);  check_eq("t1_pend", data_o, 32'h0);
    rd_reg(16'd20); check_eq("t1_id", data_o, 32'hFFFF_FFFF);

    // T2 edge source timing and clear
    wr_reg(16'd12, 32'h1);
    wr_reg(16'd4, 32'h1);
    src_v = 8'h01;
    rd_reg(16'd0); irq_seen[0] = irq_o;
    src_v = 8'h00;
    for (int i = 1; i < 4; i++) begin rd_reg(16'd0); irq_seen[i] = irq_o; end
    check_eq("t2_irq_lat", {28'h0, irq_seen[3:0]}, 32'h8);
    rd_reg(16'd0);  check_eq("t2_pend", data_o, 32'h1);
    rd_reg(16'd20); check_eq("t2_id", data_o, 32'h0);
    wr_reg(16'd8, 32'h1);
    check_eq("t2_irq_clr1", {31'h0, irq_o}, 32'h1);
    rd_reg(16'd0);
    check_eq("t2_irq_clr2", {31'h0, irq_o}, 32'h0);
    rd_reg(16'd20); check_eq("t2_id_none", data_o, 32'hFFFF_FFFF);

    // T3 level source survives clear while high
    wr_reg(16'd12, 32'h0);
    wr_reg(16'd4, 32'h4);
    src_v = 8'h04;
    idle(4);
    wr_reg(16'd8, 32'h4);
    rd_reg(16'd0); check_eq("t3_pend_hold", data_o, 32'h4);
    check_eq("t3_irq_hold", {31'h0, irq_o}, 32'h1);
    src_v = 8'h00;
    idle(3);
    wr_reg(16'd8, 32'h4);
    idle(1);
    rd_reg(16'd0); check_eq("t3_pend_clr", data_o, 32'h0);
    check_eq("t3_irq_clr", {31'h0, irq_o}, 32'h0);

    // T4 priority and mask
    wr_reg(16'd12, 32'h2A);
    wr_reg(16'd4, 32'h0A);
    src_v = 8'h2A;
    idle(1);
    src_v = 8'h00;
    idle(3);
    rd_reg(16'd0);  check_eq("t4_pend", data_o, 32'h2A);
    rd_reg(16'd16); check_eq("t4_active", data_o, 32'h0A);
    rd_reg(16'd20); check_eq("t4_id", data_o, 32'h1);
    wr_reg(16'd8, 32'h02);
    rd_reg(16'd20); check_eq("t4_id_next", data_o, 32'h3);

    // T5 set colliding with clear on the same edge
    wr_reg(16'd8, 32'hFF);
    wr_reg(16'd12, 32'h10);
    wr_reg(16'd4, 32'h10);
    src_v = 8'h10;
    idle(1);
    src_v = 8'h00;
    idle(1);
    wr_reg(16'd8, 32'h10);
    rd_reg(16'd0); check_eq("t5_collide", data_o & 32'h10, 32'h10);

    // T6 bus width, unmapped offsets, asynchronous reset with irq high
    wr_reg(16'd4, 32'hFFFF_FFFF);
    rd_reg(16'd4);  check_eq("t6_en_mask", data_o, 32'hFF);
    rd_reg(16'd24); check_eq("t6_off6", data_o, 32'h0);
    rd_reg(16'd28); check_eq("t6_off7", data_o, 32'h0);
    rd_reg(16'd2);  check_eq("t6_misalign", data_o, 32'h0);
    check_eq("t6_irq_pre", {31'h0, irq_o}, 32'h1);
    #2;
    do_reset();
    @(negedge clk_i);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) src_v[b] = ~src_v[b];
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7) * 4);
      step(a, $urandom, $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

endmodule
